i2c_tx_pkt_arb: RTL
===================

// Module: i2c_tx_pkt_arb
// PURPOSE
//  Packet-atomic arbiter in front of the i2c tx FIFO write port. Two requesters share the FIFO:
//  req0 = CPU wishbone path, req1 = hardware auto-report source.
//  Grants whole PKG_LEN-word packets only when the FIFO has room, so the i2c_phy never sees
//  interleaved or partial packets. Sits between the requesters and the tx_fifo din/wr_en port.
// PARAMETERS
//  PKG_LEN     10    words per packet (1..255)
//  FIFO_DEPTH  256   tx FIFO capacity in words
//  TO_CYCLES   1024  max idle cycles of owner mid-packet before padding (>=2)
// PORTS
//  CLK_I          in   1   clock
//  RST_I          in   1   reset, asynchronous, active-high
//  flush_i        in   1   tx FIFO flush (same pulse as tx reset); aborts current packet
//  req0_vld_i     in   1   requester 0 word valid
//  req0_dat_i     in   32  requester 0 word
//  req0_rdy_o     out  1   requester 0 word accepted when vld&rdy
//  req1_vld_i     in   1   requester 1 word valid
//  req1_dat_i     in   32  requester 1 word
//  req1_rdy_o     out  1   requester 1 word accepted when vld&rdy
//  tx_data_count  in   9   tx FIFO occupancy
//  tx_din         out  32  FIFO write data
//  tx_wr_en       out  1   FIFO write strobe
//  gnt_o          out  2   one-hot current owner
//  busy_o         out  1   state != IDLE
//  pad_err_o      out  1   sticky: a packet was zero-padded on timeout; cleared by flush_i
//  pkt_cnt0_o     out  16  packets completed for req0 (wraps)
//  pkt_cnt1_o     out  16  packets completed for req1 (wraps)
// BEHAVIOUR
//  Reset: all outputs 0; state IDLE; word counter 0; timeout counter 0; last_owner=1 (req0 wins first).
//  FSM: IDLE -> XFER -> (PAD) -> GAP -> IDLE.
//  - IDLE: request = reqN_vld_i. Grant if any request AND tx_data_count+PKG_LEN <= FIFO_DEPTH
//    (10-bit compare, no overflow). Grant is registered; gnt_o valid next cycle in XFER; rdy low in IDLE.
//  - XFER: rdy_o = gnt of that port only. Each vld&rdy -> next cycle tx_wr_en=1, tx_din=word
//    (1-cycle latency); word count +1. Word PKG_LEN accepted -> GAP, pkt_cntN+1.
//    Owner vld low: timeout counter +1, reset on each accept; reaching TO_CYCLES -> PAD.
//  - PAD: rdy low; writes 32'h0 one per cycle until word count = PKG_LEN; pad_err_o<=1; -> GAP.
//    Padded packet still increments owner pkt_cnt.
//  - GAP: 2 cycles, gnt_o=0, no writes, so tx_data_count reflects the last write before re-arbitration.
//  Arbitration (default): round-robin. Both request -> grant != last_owner; single request -> that port.
//    last_owner updated on grant.
//  Non-owner vld held high is never accepted; it waits (no drop).
//  Space insufficient: stay IDLE, no grant, no rdy, even if requests pending.
//  Back-to-back: same requester may be re-granted after GAP if the other is not requesting.
//  flush_i: highest priority in any state. Next cycle: IDLE, gnt_o=0, rdy low, tx_wr_en=0,
//    counters for word/timeout cleared, pad_err_o cleared; pkt_cnt*/last_owner kept.
//    Partial packet discarded (FIFO is being reset).
//  pkt_cnt wraps 16'hFFFF -> 0.
// CONFIGURATION
//  I2C_TXARB_PRIO_EN defined: fixed priority, req0 always wins when both request.
//    last_owner still tracked, not used.
//  Not defined: round-robin as above.
// TESTING
//  1) Single pkt: count=0, req0 sends 10 words A0..A9 -> 10 tx_wr_en, data in order,
//     pkt_cnt0=1, then GAP 2 cycles, IDLE.
//  2) Contention: req0 & req1 vld in same cycle from reset -> req0 pkt then req1 pkt then req0
//     (RR); with I2C_TXARB_PRIO_EN -> req0 repeatedly while held.
//  3) Full: tx_data_count=247 -> no grant; drop to 246 -> grant, 10 writes.
//  4) Timeout: TO_CYCLES=16, req1 sends 4 words then drops vld -> after 16 cycles six 32'h0
//     writes, pad_err_o=1, pkt_cnt1=1.
//  5) Flush mid-packet: flush_i after word 5 -> tx_wr_en low next cycle, gnt_o=0, pad_err_o=0,
//     pkt_cnt unchanged; next request granted normally.
//  6) Reset mid-XFER: RST_I asserted -> all outputs 0 immediately, req0 wins first after release.

Source files
------------

// File: rtl/i2c_tx_pkt_arb.sv
// i2c_tx_pkt_arb: packet-atomic arbiter in front of the i2c tx FIFO write port.
// Two requesters (req0 = CPU wishbone path, req1 = hardware auto-report) share the
// FIFO. Only whole PKG_LEN-word packets are granted, and only when the FIFO has room.
// A stalled owner is zero-padded to a full packet after TO_CYCLES idle cycles.
// Build option: define I2C_TXARB_PRIO_EN for fixed priority (req0 wins ties);
// otherwise ties are broken round-robin.
module i2c_tx_pkt_arb #(
   parameter int PKG_LEN    = 10,
   parameter int FIFO_DEPTH = 256,
   parameter int TO_CYCLES  = 1024
) (
   input  logic        CLK_I,
   input  logic        RST_I,
   input  logic        flush_i,
   input  logic        req0_vld_i,
   input  logic [31:0] req0_dat_i,
   output logic        req0_rdy_o,
   input  logic        req1_vld_i,
   input  logic [31:0] req1_dat_i,
   output logic        req1_rdy_o,
   input  logic [8:0]  tx_data_count,
   output logic [31:0] tx_din,
   output logic        tx_wr_en,
   output logic [1:0]  gnt_o,
   output logic        busy_o,
   output logic        pad_err_o,
   output logic [15:0] pkt_cnt0_o,
   output logic [15:0] pkt_cnt1_o
);

   localparam int TO_W = $clog2(TO_CYCLES + 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      XFER = 2'd1,
      PAD  = 2'd2,
      GAP  = 2'd3
   } state_t;

   state_t          state;
   logic [7:0]      wcnt;
   logic [TO_W-1:0] to_cnt;
   logic            gap_cnt;
   logic            last_owner;

   logic [9:0]      room_sum;
   logic            space_ok;
   logic            any_req;
   logic            pick;
   logic            own_vld;
   logic [31:0]     own_dat;
   logic            word_last;
   logic            to_last;

   // Room check, owner data select and arbitration decision for the next grant
   always_comb begin
      room_sum  = {1'b0, tx_data_count} + 10'(PKG_LEN);
      space_ok  = (room_sum <= 10'(FIFO_DEPTH));
      any_req   = req0_vld_i | req1_vld_i;
      own_vld   = gnt_o[1] ? req1_vld_i : req0_vld_i;
      own_dat   = gnt_o[1] ? req1_dat_i : req0_dat_i;
      word_last = (wcnt == 8'(PKG_LEN - 1));
      to_last   = (to_cnt == TO_W'(TO_CYCLES - 1));
      pick      = 1'b0;
      if (req0_vld_i && req1_vld_i) begin
`ifdef I2C_TXARB_PRIO_EN
         pick = 1'b0;
`else
         pick = ~last_owner;
`endif
      end else begin
         pick = req1_vld_i;
      end
   end

   assign busy_o = (state != IDLE);

   // Packet FSM with registered grant, ready, write strobe and statistics
   always_ff @(posedge CLK_I or posedge RST_I) begin
      if (RST_I) begin
         state      <= IDLE;
         wcnt       <= '0;
         to_cnt     <= '0;
         gap_cnt    <= 1'b0;
         last_owner <= 1'b1;
         gnt_o      <= 2'b00;
         req0_rdy_o <= 1'b0;
         req1_rdy_o <= 1'b0;
         tx_wr_en   <= 1'b0;
         tx_din     <= '0;
         pad_err_o  <= 1'b0;
         pkt_cnt0_o <= '0;
         pkt_cnt1_o <= '0;
      end else if (flush_i) begin
         // FIFO is being reset: drop any partial packet, keep statistics and RR history
         state      <= IDLE;
         wcnt       <= '0;
         to_cnt     <= '0;
         gap_cnt    <= 1'b0;
         gnt_o      <= 2'b00;
         req0_rdy_o <= 1'b0;
         req1_rdy_o <= 1'b0;
         tx_wr_en   <= 1'b0;
         pad_err_o  <= 1'b0;
      end else begin
         tx_wr_en <= 1'b0;
         case (state)
            IDLE: begin
               if (any_req && space_ok) begin
                  state      <= XFER;
                  gnt_o      <= pick ? 2'b10 : 2'b01;
                  req0_rdy_o <= ~pick;
                  req1_rdy_o <= pick;
                  last_owner <= pick;
                  wcnt       <= '0;
                  to_cnt     <= '0;
               end
            end
            XFER: begin
               // Owner's ready is high for the whole transfer, so vld alone means accept
               if (own_vld) begin
                  tx_wr_en <= 1'b1;
                  tx_din   <= own_dat;
                  to_cnt   <= '0;
                  if (word_last) begin
                     state      <= GAP;
                     gap_cnt    <= 1'b0;
                     wcnt       <= '0;
                     gnt_o      <= 2'b00;
                     req0_rdy_o <= 1'b0;
                     req1_rdy_o <= 1'b0;
                     if (gnt_o[1]) pkt_cnt1_o <= pkt_cnt1_o + 16'd1;
                     else          pkt_cnt0_o <= pkt_cnt0_o + 16'd1;
                  end else begin
                     wcnt <= wcnt + 8'd1;
                  end
               end else if (to_last) begin
                  state      <= PAD;
                  to_cnt     <= '0;
                  req0_rdy_o <= 1'b0;
                  req1_rdy_o <= 1'b0;
               end else begin
                  to_cnt <= to_cnt + 1'b1;
               end
            end
            PAD: begin
               tx_wr_en  <= 1'b1;
               tx_din    <= 32'h0;
               pad_err_o <= 1'b1;
               if (word_last) begin
                  state   <= GAP;
                  gap_cnt <= 1'b0;
                  wcnt    <= '0;
                  gnt_o   <= 2'b00;
                  if (gnt_o[1]) pkt_cnt1_o <= pkt_cnt1_o + 16'd1;
                  else          pkt_cnt0_o <= pkt_cnt0_o + 16'd1;
               end else begin
                  wcnt <= wcnt + 8'd1;
               end
            end
            GAP: begin
               // Two quiet cycles so tx_data_count settles before the next room check
               gap_cnt <= ~gap_cnt;
               if (gap_cnt) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
